// File: rtl/status_pkg.sv
// Shared definitions for the processor status register and the controller
// that drives it: flag commands, P-byte bit positions and ALU capture-mask bits.
package status_pkg;

    // Flag set/clear commands issued by the controller. Every 3-bit code is
    // assigned, so no illegal encodings can be produced.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        SEC  = 3'd1,
        CLC  = 3'd2,
        SEI  = 3'd3,
        CLI  = 3'd4,
        SED  = 3'd5,
        CLD  = 3'd6,
        CLV  = 3'd7
    } flag_op_t;

    // Bit positions of each flag within the P byte (push/pull image).
    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_U = 5;
    localparam int FLAG_B = 4;
    localparam int FLAG_D = 3;
    localparam int FLAG_I = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // Bit positions within upd_mask (ALU capture enables).
    localparam int UPD_N = 3;
    localparam int UPD_V = 2;
    localparam int UPD_Z = 1;
    localparam int UPD_C = 0;

    // The six stored flags; bits 5 and 4 of P have no storage.
    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    // Power-on / reset state: only I is set.
    localparam flags_t FLAGS_RESET = '{n: 1'b0, v: 1'b0, d: 1'b0,
                                       i: 1'b1, z: 1'b0, c: 1'b0};

    // Build the 8-bit push image from the stored flags and the B value.
    function automatic logic [7:0] pack_p(input flags_t f, input logic brk);
        logic [7:0] p;
        p         = 8'h00;
        p[FLAG_N] = f.n;
        p[FLAG_V] = f.v;
        p[FLAG_U] = 1'b1;
        p[FLAG_B] = brk;
        p[FLAG_D] = f.d;
        p[FLAG_I] = f.i;
        p[FLAG_Z] = f.z;
        p[FLAG_C] = f.c;
        return p;
    endfunction

    // Extract the six stored flags from a pulled P byte (U and B dropped).
    function automatic flags_t unpack_p(input logic [7:0] p);
        flags_t f;
        f.n = p[FLAG_N];
        f.v = p[FLAG_V];
        f.d = p[FLAG_D];
        f.i = p[FLAG_I];
        f.z = p[FLAG_Z];
        f.c = p[FLAG_C];
        return f;
    endfunction

endpackage

// File: rtl/status_reg.sv
// Processor status register (P) for the hmc-6502 datapath. Captures ALU flags
// under a per-flag mask, executes flag set/clear and PLP/RTI loads, builds the
// push image, and keeps the instruction-delayed IRQ mask.
module status_reg
    import status_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    input  logic       alu_c_out,
    input  logic [3:0] upd_mask,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] p_in,
    input  logic       irq_take,
    input  logic       push_brk,
    input  logic       instr_done,
    input  logic       irq_line,
    output logic [7:0] p_out,
    output logic       c_flag,
    output logic       d_flag,
    output logic       i_flag,
    output logic       irq_mask,
    output logic       irq_req
);

    flags_t   flags_q;
    flags_t   flags_d;
    logic     mask_q;
    logic     mask_d;
    flag_op_t op;

    assign op = flag_op_t'(flag_op);

    // Next-state flags: a pull overrides everything, otherwise each flag
    // follows its own ALU capture enable with the flag command taking priority.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        flags_d = flags_q;
        if (p_load) begin
            flags_d = unpack_p(p_in);
        end else begin
            if (upd_mask[UPD_N]) flags_d.n = alu_negative;
            if (upd_mask[UPD_V]) flags_d.v = alu_overflow;
            if (upd_mask[UPD_Z]) flags_d.z = alu_zero;
            if (upd_mask[UPD_C]) flags_d.c = alu_c_out;
            case (op)
                SEC:     flags_d.c = 1'b1;
                CLC:     flags_d.c = 1'b0;
                SEI:     flags_d.i = 1'b1;
                CLI:     flags_d.i = 1'b0;
                SED:     flags_d.d = 1'b1;
                CLD:     flags_d.d = 1'b0;
                CLV:     flags_d.v = 1'b0;
                default: ;
            endcase
            // Interrupt entry masks further IRQs even against a concurrent CLI.
            if (irq_take) flags_d.i = 1'b1;
        end
    end

    // Effective IRQ mask: tracks I only at instruction boundaries, so a
    // CLI/SEI/PLP takes effect one instruction later; interrupt entry
    // (when not overridden by a pull) masks immediately.
    always_comb begin
        mask_d = mask_q;
        if (irq_take && !p_load) begin
            mask_d = 1'b1;
        end else if (instr_done) begin
            mask_d = flags_d.i;
        end
    end

    // Flag and mask storage with synchronous reset; reset discards any
    // update presented in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            flags_q <= FLAGS_RESET;
            mask_q  <= 1'b1;
        end else begin
            flags_q <= flags_d;
            mask_q  <= mask_d;
        end
    end

    assign p_out    = pack_p(flags_q, push_brk);
    assign c_flag   = flags_q.c;
    assign d_flag   = flags_q.d;
    assign i_flag   = flags_q.i;
    assign irq_mask = mask_q;
    assign irq_req  = irq_line & ~mask_q;

endmodule
